gtfmac_vnc_rx_len_mon: RTL and testbench
========================================

Name: gtfmac_vnc_rx_len_mon

Overview:
- Parametrised, multi-channel successor to the single-channel RX packet monitor.
- Sits after the per-channel GTFMAC RX interface adapters, on their dout_* streams (ena/sop/eop/mty/err).
- Per channel: tracks frame length against programmable min/max, classifies each frame, and keeps saturating counters.
- Counters are snapshotted and cleared on stat_tick; snapshots are read through a channel-select port.

Parameters:
- N_CH, 4, number of monitored channels (1..16).
- DW, 64, data beat width in bits; BYTES = DW/8, MTY_W = log2(BYTES).
- LEN_W, 14, width of frame length counter and min/max controls.
- CNT_W, 32, width of frame event counters.
- BCNT_W, 48, width of byte counter.

Ports:
- clk  in  1  monitor clock (RX user clock).
- rst_n  in  1  asynchronous active-low reset.
- din_ena  in  N_CH  per-channel beat valid.
- din_sop  in  N_CH  start of frame.
- din_eop  in  N_CH  end of frame.
- din_mty  in  N_CH*MTY_W  empty bytes on eop beat; channel c uses bits [c*MTY_W +: MTY_W].
- din_err  in  N_CH  frame error, sampled on eop beat.
- ctl_en  in  N_CH  per-channel monitor enable.
- ctl_min_len  in  LEN_W  minimum legal length in bytes, inclusive.
- ctl_max_len  in  LEN_W  maximum legal length in bytes, inclusive.
- stat_tick  in  1  one-cycle snapshot/clear strobe.
- rd_ch  in  log2(N_CH) (min 1)  snapshot channel select.
- stat_good  out  CNT_W  snapshot good-frame count.
- stat_bytes  out  BCNT_W  snapshot good-frame byte count.
- stat_runt  out  CNT_W  snapshot runt count.
- stat_oversize  out  CNT_W  snapshot oversize count.
- stat_err  out  CNT_W  snapshot errored-frame count.
- stat_proto  out  CNT_W  snapshot framing-violation count.
- stat_done  out  1  pulse one cycle after stat_tick.

Behaviour:
- Reset: all live counters, snapshots, length counters and stat_* outputs are 0; every channel FSM is in IDLE.
- Per-channel FSM, states IDLE and IN_PKT. Only beats with ena=1 are considered.
  - IDLE, sop&eop: single-beat frame; len = BYTES - mty; classify; stay in IDLE.
  - IDLE, sop only: len = BYTES; go to IN_PKT.
  - IDLE, no sop: proto+1; beat ignored.
  - IN_PKT, no sop, no eop: len += BYTES.
  - IN_PKT, eop: len += BYTES - mty; classify; go to IDLE.
  - IN_PKT, sop: proto+1; current frame discarded uncounted; new frame restarts as if from IDLE (sop&eop handled as single-beat).
- Length accumulation saturates at 2^LEN_W-1; a saturated frame classifies as oversize.
- Classification priority at eop:
  - err=1: err+1.
  - else len < min: runt+1.
  - else len > max: oversize+1.
  - else: good+1 and bytes += len.
- ctl_en[c]=0: channel c returns to IDLE, the in-flight frame is dropped uncounted, and inputs are ignored. Live counters hold their values.
- All counters saturate at all-ones; no wrap.
- stat_tick:
  - Every channel's snapshot loads live value plus any increment occurring in the same cycle.
  - Live counters clear to 0.
  - stat_done asserts the next cycle.
- Read path: stat_* reflect snapshot[rd_ch] registered, one-cycle latency. rd_ch >= N_CH returns 0.
- min > max is not checked: frames with err=0 classify as runt or oversize, never good.
- Reset mid-frame: immediate return to IDLE with all state zeroed.

Optional Feature:
- Macro GTFMAC_VNC_RX_LEN_MON_HIST_EN.
- Defined: adds per-channel length histogram, 7 bins of CNT_W bits each: <=64, 65-127, 128-255, 256-511, 512-1023, 1024-1518, >1518.
  - Incremented for every classified frame with err=0, including runt and oversize.
  - Snapshotted and cleared on stat_tick like the other counters.
  - Extra input rd_bin (3 bits) and output stat_hist (CNT_W); stat_hist is snapshot[rd_ch][rd_bin] with one-cycle latency.
  - rd_bin=7 returns 0.
- Undefined: no histogram logic and no rd_bin/stat_hist ports.

Test Plan:
- Common setup: DW=64, min=64, max=1518.
- Good frame and tick: ch0 frame of 8 beats, mty=4 on eop (60 bytes) -> runt=1. Then 190 beats, mty=0 (1520 bytes) -> oversize=1. Then 100 beats, mty=2 (798 bytes) -> good=1, bytes=798. After stat_tick -> stat_done next cycle; rd_ch=0 shows runt=1, oversize=1, good=1, bytes=798. A second tick reads all 0.
- Framing violations: ch1 beat with no sop while in IDLE, then sop, 3 beats, sop&eop with mty=0 -> proto=2, runt=1 (8 bytes), good=0.
- Error priority: ch2 60-byte frame with err=1 on eop -> err=1, runt=0.
- Enable drop: ch3 sop plus 5 beats, ctl_en[3]=0 for 1 cycle, then eop -> no frame counted; eop in IDLE gives proto=1.
- Tick coincidence: ch0 good 64-byte eop on the same cycle as stat_tick -> snapshot good=1, bytes=64; next snapshot good=0. Force a counter preload to CNT_W all-ones, add one event -> value holds all-ones.
- Reset mid-frame: rst_n low during IN_PKT, then a complete 64-byte frame -> good=1 only; all stat_* read 0 immediately after reset.

Source files
------------

// File: rtl/gtfmac_vnc_rx_len_mon_if.sv
// RX beat stream bundle from the per-channel GTFMAC RX adapters.
// Carries ena/sop/eop/mty/err for all channels side by side.
interface gtfmac_vnc_rx_len_mon_if #(
  parameter int N_CH  = 4,
  parameter int MTY_W = 3
);
  logic [N_CH-1:0]       din_ena;
  logic [N_CH-1:0]       din_sop;
  logic [N_CH-1:0]       din_eop;
  logic [N_CH*MTY_W-1:0] din_mty;
  logic [N_CH-1:0]       din_err;

  modport master (
    output din_ena, din_sop, din_eop,
    output din_mty, din_err
  );

  modport slave (
    input din_ena, din_sop, din_eop,
    input din_mty, din_err
  );
endinterface

// File: rtl/gtfmac_vnc_rx_len_mon.sv
// Multi-channel RX frame length monitor with snapshot statistics.
// Optional length histogram: define GTFMAC_VNC_RX_LEN_MON_HIST_EN.
module gtfmac_vnc_rx_len_mon #(
  parameter int N_CH   = 4,
  parameter int DW     = 64,
  parameter int LEN_W  = 14,
  parameter int CNT_W  = 32,
  parameter int BCNT_W = 48,
  localparam int BYTES = DW / 8,
  localparam int MTY_W = $clog2(BYTES),
  localparam int RD_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  gtfmac_vnc_rx_len_mon_if.slave rx,
  input  logic [N_CH-1:0]        ctl_en,
  input  logic [LEN_W-1:0]       ctl_min_len,
  input  logic [LEN_W-1:0]       ctl_max_len,
  input  logic                   stat_tick,
  input  logic [RD_W-1:0]        rd_ch,
  output logic [CNT_W-1:0]       stat_good,
  output logic [BCNT_W-1:0]      stat_bytes,
  output logic [CNT_W-1:0]       stat_runt,
  output logic [CNT_W-1:0]       stat_oversize,
  output logic [CNT_W-1:0]       stat_err,
  output logic [CNT_W-1:0]       stat_proto,
  output logic                   stat_done
`ifdef GTFMAC_VNC_RX_LEN_MON_HIST_EN
  ,
  input  logic [2:0]             rd_bin,
  output logic [CNT_W-1:0]       stat_hist
`endif
);

  typedef enum logic {IDLE, IN_PKT} st_t;

  localparam logic [MTY_W:0] FULL = (MTY_W+1)'(BYTES);

  st_t              st_q    [N_CH];
  st_t              st_d    [N_CH];
  logic [LEN_W-1:0] len_q   [N_CH];
  logic [LEN_W-1:0] len_d   [N_CH];
  logic [LEN_W-1:0] fin_len [N_CH];
  logic [N_CH-1:0]  fin;
  logic [N_CH-1:0]  inc_good, inc_runt, inc_ovs;
  logic [N_CH-1:0]  inc_err, inc_proto;

  logic [CNT_W-1:0]  good_q [N_CH], good_s [N_CH], good_n [N_CH];
  logic [CNT_W-1:0]  runt_q [N_CH], runt_s [N_CH], runt_n [N_CH];
  logic [CNT_W-1:0]  ovs_q  [N_CH], ovs_s  [N_CH], ovs_n  [N_CH];
  logic [CNT_W-1:0]  err_q  [N_CH], err_s  [N_CH], err_n  [N_CH];
  logic [CNT_W-1:0]  prt_q  [N_CH], prt_s  [N_CH], prt_n  [N_CH];
  logic [BCNT_W-1:0] byt_q  [N_CH], byt_s  [N_CH], byt_n  [N_CH];

  function automatic logic [LEN_W-1:0] len_add(
    input logic [LEN_W-1:0] a,
    input logic [MTY_W:0]   b
  );
    logic [LEN_W:0] s;
    s = {1'b0, a} + (LEN_W+1)'(b);
    return s[LEN_W] ? '1 : s[LEN_W-1:0];
  endfunction

  function automatic logic [CNT_W-1:0] cnt_inc(
    input logic [CNT_W-1:0] v,
    input logic             i
  );
    return (i && !(&v)) ? v + CNT_W'(1) : v;
  endfunction

  function automatic logic [BCNT_W-1:0] byt_add(
    input logic [BCNT_W-1:0] v,
    input logic [LEN_W-1:0]  l,
    input logic              i
  );
    logic [BCNT_W:0] s;
    s = {1'b0, v} + (BCNT_W+1)'(l);
    if (!i) return v;
    return s[BCNT_W] ? '1 : s[BCNT_W-1:0];
  endfunction

  // Framing FSM next state and per-beat length accumulation
  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      logic [MTY_W:0] tail;
      tail         = FULL - {1'b0, rx.din_mty[c*MTY_W +: MTY_W]};
      st_d[c]      = st_q[c];
      len_d[c]     = len_q[c];
      fin[c]       = 1'b0;
      fin_len[c]   = '0;
      inc_proto[c] = 1'b0;
      if (!ctl_en[c]) begin
        st_d[c]  = IDLE;
        len_d[c] = '0;
      end else if (rx.din_ena[c]) begin
        if (st_q[c] == IN_PKT && !rx.din_sop[c]) begin
          if (rx.din_eop[c]) begin
            fin[c]     = 1'b1;
            fin_len[c] = len_add(len_q[c], tail);
            st_d[c]    = IDLE;
            len_d[c]   = '0;
          end else begin
            len_d[c] = len_add(len_q[c], FULL);
          end
        end else begin
          inc_proto[c] = !rx.din_sop[c] || st_q[c] == IN_PKT;
          if (rx.din_sop[c] && rx.din_eop[c]) begin
            fin[c]     = 1'b1;
            fin_len[c] = LEN_W'(tail);
            st_d[c]    = IDLE;
            len_d[c]   = '0;
          end else if (rx.din_sop[c]) begin
            st_d[c]  = IN_PKT;
            len_d[c] = LEN_W'(FULL);
          end
        end
      end
    end
  end

  // FSM state and length registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < N_CH; c++) begin
        st_q[c]  <= IDLE;
        len_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        st_q[c]  <= st_d[c];
        len_q[c] <= len_d[c];
      end
    end
  end

  // Classify finished frames; saturated length counts as oversize
  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      inc_err[c]  = fin[c] && rx.din_err[c];
      inc_runt[c] = fin[c] && !rx.din_err[c] &&
                    fin_len[c] < ctl_min_len;
      inc_ovs[c]  = fin[c] && !rx.din_err[c] &&
                    fin_len[c] >= ctl_min_len &&
                    (fin_len[c] > ctl_max_len || &fin_len[c]);
      inc_good[c] = fin[c] && !rx.din_err[c] &&
                    !inc_runt[c] && !inc_ovs[c];
    end
  end

  // Saturating next values of live counters
  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      good_n[c] = cnt_inc(good_q[c], inc_good[c]);
      runt_n[c] = cnt_inc(runt_q[c], inc_runt[c]);
      ovs_n[c]  = cnt_inc(ovs_q[c], inc_ovs[c]);
      err_n[c]  = cnt_inc(err_q[c], inc_err[c]);
      prt_n[c]  = cnt_inc(prt_q[c], inc_proto[c]);
      byt_n[c]  = byt_add(byt_q[c], fin_len[c], inc_good[c]);
    end
  end

  // Live counters accumulate; stat_tick moves them into snapshots
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < N_CH; c++) begin
        good_q[c] <= '0; good_s[c] <= '0;
        runt_q[c] <= '0; runt_s[c] <= '0;
        ovs_q[c]  <= '0; ovs_s[c]  <= '0;
        err_q[c]  <= '0; err_s[c]  <= '0;
        prt_q[c]  <= '0; prt_s[c]  <= '0;
        byt_q[c]  <= '0; byt_s[c]  <= '0;
      end
    end else if (stat_tick) begin
      for (int c = 0; c < N_CH; c++) begin
        good_s[c] <= good_n[c]; good_q[c] <= '0;
        runt_s[c] <= runt_n[c]; runt_q[c] <= '0;
        ovs_s[c]  <= ovs_n[c];  ovs_q[c]  <= '0;
        err_s[c]  <= err_n[c];  err_q[c]  <= '0;
        prt_s[c]  <= prt_n[c];  prt_q[c]  <= '0;
        byt_s[c]  <= byt_n[c];  byt_q[c]  <= '0;
      end
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        good_q[c] <= good_n[c];
        runt_q[c] <= runt_n[c];
        ovs_q[c]  <= ovs_n[c];
        err_q[c]  <= err_n[c];
        prt_q[c]  <= prt_n[c];
        byt_q[c]  <= byt_n[c];
      end
    end
  end

  // Registered snapshot read mux and tick completion pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_good     <= '0;
      stat_bytes    <= '0;
      stat_runt     <= '0;
      stat_oversize <= '0;
      stat_err      <= '0;
      stat_proto    <= '0;
      stat_done     <= 1'b0;
    end else begin
      stat_done <= stat_tick;
      if (int'(rd_ch) < N_CH) begin
        stat_good     <= good_s[rd_ch];
        stat_bytes    <= byt_s[rd_ch];
        stat_runt     <= runt_s[rd_ch];
        stat_oversize <= ovs_s[rd_ch];
        stat_err      <= err_s[rd_ch];
        stat_proto    <= prt_s[rd_ch];
      end else begin
        stat_good     <= '0;
        stat_bytes    <= '0;
        stat_runt     <= '0;
        stat_oversize <= '0;
        stat_err      <= '0;
        stat_proto    <= '0;
      end
    end
  end

`ifdef GTFMAC_VNC_RX_LEN_MON_HIST_EN
  localparam int NB = 7;

  logic [CNT_W-1:0] hist_q [N_CH][NB];
  logic [CNT_W-1:0] hist_s [N_CH][NB];
  logic [CNT_W-1:0] hist_n [N_CH][NB];

  function automatic logic [2:0] len_bin(input logic [LEN_W-1:0] l);
    if (l <= LEN_W'(64))   return 3'd0;
    if (l <= LEN_W'(127))  return 3'd1;
    if (l <= LEN_W'(255))  return 3'd2;
    if (l <= LEN_W'(511))  return 3'd3;
    if (l <= LEN_W'(1023)) return 3'd4;
    if (l <= LEN_W'(1518)) return 3'd5;
    return 3'd6;
  endfunction

  // Histogram bin increments for every classified error-free frame
  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      for (int b = 0; b < NB; b++) begin
        hist_n[c][b] = cnt_inc(hist_q[c][b],
          fin[c] && !rx.din_err[c] &&
          len_bin(fin_len[c]) == 3'(b));
      end
    end
  end

  // Histogram live bins and snapshots
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < N_CH; c++) begin
        for (int b = 0; b < NB; b++) begin
          hist_q[c][b] <= '0;
          hist_s[c][b] <= '0;
        end
      end
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        for (int b = 0; b < NB; b++) begin
          if (stat_tick) begin
            hist_s[c][b] <= hist_n[c][b];
            hist_q[c][b] <= '0;
          end else begin
            hist_q[c][b] <= hist_n[c][b];
          end
        end
      end
    end
  end

  // Registered histogram read; bin 7 and absent channels read 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_hist <= '0;
    end else if (int'(rd_ch) < N_CH && rd_bin != 3'd7) begin
      stat_hist <= hist_s[rd_ch][rd_bin];
    end else begin
      stat_hist <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_gtfmac_vnc_rx_len_mon.sv
// Directed bench for gtfmac_vnc_rx_len_mon (DW=64, min 64, max 1518).
// A second instance with 2-bit counters exercises saturation.
module tb_gtfmac_vnc_rx_len_mon;

  localparam int N_CH  = 4;
  localparam int MTY_W = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  ctl_en, ctl_en2;
  logic [13:0] ctl_min_len, ctl_max_len;
  logic        stat_tick, stat_tick2;
  logic [1:0]  rd_ch;

  logic [31:0] stat_good, stat_runt, stat_oversize;
  logic [31:0] stat_err, stat_proto;
  logic [47:0] stat_bytes;
  logic        stat_done;

  logic [1:0]  s_good, s_runt, s_ovs, s_err, s_proto;
  logic [47:0] s_bytes;
  logic        s_done;

`ifdef GTFMAC_VNC_RX_LEN_MON_HIST_EN
  logic [2:0]  rd_bin;
  logic [31:0] stat_hist;
  logic [1:0]  s_hist;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  gtfmac_vnc_rx_len_mon_if #(.N_CH(N_CH), .MTY_W(MTY_W)) rx_if ();

  gtfmac_vnc_rx_len_mon dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx            (rx_if),
    .ctl_en        (ctl_en),
    .ctl_min_len   (ctl_min_len),
    .ctl_max_len   (ctl_max_len),
    .stat_tick     (stat_tick),
    .rd_ch         (rd_ch),
    .stat_good     (stat_good),
    .stat_bytes    (stat_bytes),
    .stat_runt     (stat_runt),
    .stat_oversize (stat_oversize),
    .stat_err      (stat_err),
    .stat_proto    (stat_proto),
    .stat_done     (stat_done)
`ifdef GTFMAC_VNC_RX_LEN_MON_HIST_EN
    ,
    .rd_bin        (rd_bin),
    .stat_hist     (stat_hist)
`endif
  );

  gtfmac_vnc_rx_len_mon #(.CNT_W(2)) dut_sat (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx            (rx_if),
    .ctl_en        (ctl_en2),
    .ctl_min_len   (ctl_min_len),
    .ctl_max_len   (ctl_max_len),
    .stat_tick     (stat_tick2),
    .rd_ch         (rd_ch),
    .stat_good     (s_good),
    .stat_bytes    (s_bytes),
    .stat_runt     (s_runt),
    .stat_oversize (s_ovs),
    .stat_err      (s_err),
    .stat_proto    (s_proto),
    .stat_done     (s_done)
`ifdef GTFMAC_VNC_RX_LEN_MON_HIST_EN
    ,
    .rd_bin        (rd_bin),
    .stat_hist     (s_hist)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    rx_if.din_ena = '0;
    rx_if.din_sop = '0;
    rx_if.din_eop = '0;
    rx_if.din_mty = '0;
    rx_if.din_err = '0;
  endtask

  task automatic beat(input int c, input bit sop, input bit eop,
                      input int mty, input bit err);
    logic [N_CH-1:0] m;
    m = N_CH'(1) << c;
    rx_if.din_ena = m;
    rx_if.din_sop = sop ? m : '0;
    rx_if.din_eop = eop ? m : '0;
    rx_if.din_err = err ? m : '0;
    rx_if.din_mty = (N_CH*MTY_W)'(mty) << (c * MTY_W);
    cyc(1);
    idle_in();
  endtask

  task automatic frame(input int c, input int nb,
                       input int mty, input bit err);
    for (int i = 0; i < nb; i++) begin
      beat(c, i == 0, i == nb - 1,
           (i == nb - 1) ? mty : 0,
           (i == nb - 1) ? err : 1'b0);
    end
  endtask

  task automatic tick();
    stat_tick = 1'b1;
    cyc(1);
    stat_tick = 1'b0;
  endtask

  task automatic rd(input int c);
    rd_ch = 2'(c);
    cyc(1);
  endtask

  initial begin
    rst_n       = 1'b0;
    ctl_en      = '1;
    ctl_en2     = '0;
    ctl_min_len = 14'd64;
    ctl_max_len = 14'd1518;
    stat_tick   = 1'b0;
    stat_tick2  = 1'b0;
    rd_ch       = '0;
`ifdef GTFMAC_VNC_RX_LEN_MON_HIST_EN
    rd_bin      = '0;
`endif
    idle_in();
    cyc(3);
    check("rst_good", stat_good, 0);
    check("rst_bytes", stat_bytes, 0);
    check("rst_done", stat_done, 0);
    rst_n = 1'b1;
    cyc(1);

    // runt, oversize, good on ch0
    frame(0, 8, 4, 1'b0);
    frame(0, 190, 0, 1'b0);
    frame(0, 100, 2, 1'b0);
    tick();
    check("tick_done", stat_done, 1);
    rd(0);
    check("done_pulse", stat_done, 0);
    check("c0_runt", stat_runt, 1);
    check("c0_ovs", stat_oversize, 1);
    check("c0_good", stat_good, 1);
    check("c0_bytes", stat_bytes, 798);
    check("c0_err", stat_err, 0);
    check("c0_proto", stat_proto, 0);
    tick();
    rd(0);
    check("c0_clr_good", stat_good, 0);
    check("c0_clr_runt", stat_runt, 0);
    check("c0_clr_ovs", stat_oversize, 0);
    check("c0_clr_bytes", stat_bytes, 0);

    // framing violations on ch1
    beat(1, 1'b0, 1'b0, 0, 1'b0);
    beat(1, 1'b1, 1'b0, 0, 1'b0);
    repeat (3) beat(1, 1'b0, 1'b0, 0, 1'b0);
    beat(1, 1'b1, 1'b1, 0, 1'b0);
    // error priority on ch2
    frame(2, 8, 4, 1'b1);
    // enable drop on ch3
    beat(3, 1'b1, 1'b0, 0, 1'b0);
    repeat (5) beat(3, 1'b0, 1'b0, 0, 1'b0);
    ctl_en[3] = 1'b0;
    cyc(1);
    ctl_en[3] = 1'b1;
    beat(3, 1'b0, 1'b1, 0, 1'b0);
    tick();
    rd(1);
    check("c1_proto", stat_proto, 2);
    check("c1_runt", stat_runt, 1);
    check("c1_good", stat_good, 0);
    rd(2);
    check("c2_err", stat_err, 1);
    check("c2_runt", stat_runt, 0);
    rd(3);
    check("c3_good", stat_good, 0);
    check("c3_runt", stat_runt, 0);
    check("c3_ovs", stat_oversize, 0);
    check("c3_proto", stat_proto, 1);

    // eop coincident with tick
    beat(0, 1'b1, 1'b0, 0, 1'b0);
    repeat (6) beat(0, 1'b0, 1'b0, 0, 1'b0);
    stat_tick = 1'b1;
    beat(0, 1'b0, 1'b1, 0, 1'b0);
    stat_tick = 1'b0;
    check("coin_done", stat_done, 1);
    rd(0);
    check("coin_good", stat_good, 1);
    check("coin_bytes", stat_bytes, 64);
    tick();
    rd(0);
    check("coin_next_good", stat_good, 0);
    check("coin_next_bytes", stat_bytes, 0);

    // saturation on 2-bit counters
    ctl_en2 = 4'b0001;
    repeat (4) frame(0, 8, 0, 1'b0);
    repeat (4) beat(0, 1'b0, 1'b0, 0, 1'b0);
    stat_tick2 = 1'b1;
    cyc(1);
    stat_tick2 = 1'b0;
    ctl_en2 = '0;
    rd(0);
    check("sat_good", s_good, 3);
    check("sat_proto", s_proto, 3);
    check("sat_bytes", s_bytes, 256);
    check("sat_runt", s_runt, 0);

    // same traffic on the wide instance, then reset mid-frame
    tick();
    rd(0);
    check("pre_rst_good", stat_good, 4);
    check("pre_rst_proto", stat_proto, 4);
    beat(0, 1'b1, 1'b0, 0, 1'b0);
    repeat (2) beat(0, 1'b0, 1'b0, 0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_good", stat_good, 0);
    check("mid_rst_bytes", stat_bytes, 0);
    check("mid_rst_proto", stat_proto, 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
    frame(0, 8, 0, 1'b0);
    tick();
    rd(0);
    check("post_rst_good", stat_good, 1);
    check("post_rst_bytes", stat_bytes, 64);
    check("post_rst_proto", stat_proto, 0);
    check("post_rst_runt", stat_runt, 0);
    check("post_rst_ovs", stat_oversize, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
